// File: rtl/rv_pkg.sv
// Shared encodings for the branch target unit: target modes and direction-counter states.
package rv_pkg;
    localparam logic [1:0] TGT_BRANCH = 2'b00;
    localparam logic [1:0] TGT_JAL    = 2'b01;
    localparam logic [1:0] TGT_JALR   = 2'b10;
    localparam logic [1:0] TGT_RSVD   = 2'b11;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction
endpackage

// File: rtl/branch_target_unit_if.sv
// IF-stage lookup and EX-stage resolve signals between the pipeline and the branch target unit.
// No handshake: every input is sampled as a level each cycle; valid qualifies the EX group only.
interface branch_target_unit_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] if_pc;
    logic            if_hit;
    logic            if_pred_taken;
    logic [XLEN-1:0] if_pred_target;
    logic            ex_valid;
    logic [1:0]      ex_mode;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_imm;
    logic            ex_cond;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic [XLEN-1:0] ex_target;
    logic            ex_taken;
    logic            ex_mispredict;
    logic [XLEN-1:0] ex_redirect_pc;
    logic            flush_btb;

    modport master (
        output if_pc, ex_valid, ex_mode, ex_pc, ex_rs1, ex_imm, ex_cond,
               ex_pred_taken, ex_pred_target, flush_btb,
        input  if_hit, if_pred_taken, if_pred_target,
               ex_target, ex_taken, ex_mispredict, ex_redirect_pc
    );

    modport slave (
        input  if_pc, ex_valid, ex_mode, ex_pc, ex_rs1, ex_imm, ex_cond,
               ex_pred_taken, ex_pred_target, flush_btb,
        output if_hit, if_pred_taken, if_pred_target,
               ex_target, ex_taken, ex_mispredict, ex_redirect_pc
    );
endinterface

// File: rtl/target_calc.sv
// Combinational control-transfer target: PC-relative for BRANCH/JAL, register-relative for JALR.
module target_calc
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      ex_mode,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_target
);
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;

    assign base = (ex_mode == TGT_JALR) ? ex_rs1 : ex_pc;
    assign sum  = base + ex_imm;
    // JALR targets always have bit 0 cleared
    assign ex_target = (ex_mode == TGT_JALR) ? {sum[XLEN-1:1], 1'b0} : sum;
endmodule

// File: rtl/branch_target_unit.sv
// Direct-mapped BTB with 2-bit direction counters plus EX-stage target resolution.
module branch_target_unit
    import rv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    localparam int IDX_W  = $clog2(ENTRIES),
    localparam int TAG_W  = XLEN - IDX_W - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_target_unit_if.slave   bus
);
    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0]  tgt_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             upd;
    logic             wr_en;
    logic [1:0]       ctr_nxt;
    logic [XLEN-1:0]  target;
    logic             taken;

    // IF lookup: zero latency, sees pre-write contents
    assign if_idx = bus.if_pc[IDX_W+1:2];
    assign if_tag = bus.if_pc[XLEN-1:IDX_W+2];
    assign bus.if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign bus.if_pred_taken  = bus.if_hit && ctr_q[if_idx][1];
    assign bus.if_pred_target = bus.if_pred_taken ? tgt_q[if_idx] : bus.if_pc + XLEN'(4);

    target_calc #(.XLEN(XLEN)) u_target_calc (
        .ex_mode   (bus.ex_mode),
        .ex_pc     (bus.ex_pc),
        .ex_rs1    (bus.ex_rs1),
        .ex_imm    (bus.ex_imm),
        .ex_target (target)
    );

    // Reserved mode behaves as an empty EX slot
    assign upd   = bus.ex_valid && (bus.ex_mode != TGT_RSVD);
    assign taken = (bus.ex_mode == TGT_BRANCH) ? bus.ex_cond : (bus.ex_mode != TGT_RSVD);

    assign bus.ex_target      = target;
    assign bus.ex_taken       = taken;
    assign bus.ex_mispredict  = upd && ((taken != bus.ex_pred_taken) ||
                                        (taken && (bus.ex_pred_target != target)));
    assign bus.ex_redirect_pc = taken ? target : bus.ex_pc + XLEN'(4);

    assign ex_idx = bus.ex_pc[IDX_W+1:2];
    assign ex_tag = bus.ex_pc[XLEN-1:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        wr_en   = 1'b0;
        ctr_nxt = ctr_q[ex_idx];
        if (upd && (ex_hit || taken)) begin
            wr_en = 1'b1;
            if (bus.ex_mode != TGT_BRANCH) ctr_nxt = CTR_ST;
            else if (!ex_hit)              ctr_nxt = CTR_WT;
            else if (taken)                ctr_nxt = ctr_inc(ctr_q[ex_idx]);
            else                           ctr_nxt = ctr_dec(ctr_q[ex_idx]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (bus.flush_btb) begin
            // Flush takes priority over any coincident update
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
        end else if (wr_en) begin
            valid_q[ex_idx] <= 1'b1;
            tag_q[ex_idx]   <= ex_tag;
            ctr_q[ex_idx]   <= ctr_nxt;
            if (taken) tgt_q[ex_idx] <= target;
        end
    end
endmodule

// File: doc/branch_target_unit.md
# branch_target_unit

Parametrised branch target unit for the RISC-V pipeline, generalising the fixed 32-bit PC + immediate adder. It pairs an EX-stage target calculator for BRANCH/JAL/JALR with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. The IF stage uses it for next-PC prediction. The EX stage uses it to resolve the real target, flag mispredictions and supply the redirect PC.

## Interface
Parameters:
- XLEN, 32, datapath and PC width
- ENTRIES, 16, BTB entries; power of two, at least 2
- IDX_W, $clog2(ENTRIES), index width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  XLEN  fetch PC
- if_hit  out  1  valid entry whose tag matches if_pc
- if_pred_taken  out  1  if_hit AND counter[1]
- if_pred_target  out  XLEN  stored target; if_pc+4 when not predicted taken
- ex_valid  in  1  EX holds a control-transfer instruction
- ex_mode  in  2  target mode (BRANCH/JAL/JALR)
- ex_pc  in  XLEN  PC of the EX instruction
- ex_rs1  in  XLEN  forwarded rs1 (JALR only)
- ex_imm  in  XLEN  sign-extended immediate
- ex_cond  in  1  branch condition from the ALU (BRANCH only)
- ex_pred_taken  in  1  prediction carried down the pipe
- ex_pred_target  in  XLEN  predicted target carried down the pipe
- ex_target  out  XLEN  computed target
- ex_taken  out  1  actual direction
- ex_mispredict  out  1  redirect required
- ex_redirect_pc  out  XLEN  correct next PC
- flush_btb  in  1  synchronous invalidate of all entries

## Operation
- Target arithmetic is modulo 2^XLEN with carries discarded:
  - BRANCH and JAL: ex_pc + ex_imm.
  - JALR: (ex_rs1 + ex_imm) with bit 0 cleared.
- ex_taken = ex_cond for BRANCH, and 1 for JAL and JALR.
- Mode encoding 2'b11 is reserved. It is treated as ex_valid=0: no update and no mispredict.
- ex_mispredict = ex_valid AND (ex_taken != ex_pred_taken OR (ex_taken AND ex_pred_target != ex_target)).
- ex_redirect_pc = ex_taken ? ex_target : ex_pc+4. The output is driven regardless of ex_mispredict.
- BTB addressing:
  - index = pc[IDX_W+1:2]
  - tag = pc[XLEN-1:IDX_W+2]
  - each entry stores {valid, tag, target, ctr[1:0]}
- Update rules, applied when ex_valid is asserted, at the index of ex_pc:
  - Hit, taken: ctr saturating-increment (max 3); target <= ex_target.
  - Hit, not taken: ctr saturating-decrement (min 0); target unchanged.
  - Miss, taken: allocate the entry with valid=1, new tag, target=ex_target, ctr=2'b10. This overwrites any previous occupant.
  - Miss, not taken: no write.
  - JAL and JALR always set ctr=2'b11.
- flush_btb clears all valid bits; counters and targets are don't-care. If flush_btb and an update coincide, flush wins and the update is dropped.

## Timing
- All EX outputs and all IF outputs are combinational; the BTB lookup has zero latency.
- BTB writes and flush take effect on the rising clk edge. A lookup in the same cycle as a write to that index sees the pre-write contents (no bypass).
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - all valid=0, ctr=2'b01, targets=0.
  - After reset: if_hit=0, if_pred_taken=0, if_pred_target=if_pc+4.
  - EX outputs are purely combinational on inputs.
- A reset mid-update abandons the write; no partial entry survives.
- Index wrap: two PCs that differ only above bit IDX_W+1 alias. The tag rejects the stale entry, and the newer allocation replaces it.
- Counter saturation: 3 + taken stays 3; 0 + not-taken stays 0.

## Structure
- Shared package `rv_pkg`:
  - TGT_BRANCH=2'b00, TGT_JAL=2'b01, TGT_JALR=2'b10
  - CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11
- Sub-module `target_calc` (combinational): ex_mode, ex_pc, ex_rs1, ex_imm in; ex_target out. It replaces the standalone PC + ImmExt adder.
- BTB storage is a register array, not SRAM: flush and reset must clear every entry in one cycle.

## Test plan
- Reset, then if_pc=0x100: if_hit=0, if_pred_taken=0, if_pred_target=0x104.
- BRANCH at ex_pc=0x100, ex_imm=0xFFFFFFF0, ex_cond=1, ex_pred_taken=0:
  - ex_target=0xF0, ex_mispredict=1, redirect=0xF0.
  - Next cycle, if_pc=0x100 gives hit, pred_taken=1, target=0xF0.
- JALR with ex_rs1=0x2001, ex_imm=0x4, ex_pred_taken=1, ex_pred_target=0x2004:
  - ex_target=0x2004, ex_mispredict=0, ctr=3.
- Counter hysteresis: after the entry reaches ctr=3, apply one not-taken (prediction stays taken), then a second not-taken (prediction flips to not taken). Also check that a fourth taken keeps ctr=3.
- Aliasing with ENTRIES=16: allocate 0x100, then allocate 0x140 (same index). Lookup at 0x100 misses; lookup at 0x140 hits.
- flush_btb together with a taken update: the next cycle shows every lookup missing, including the updated PC.
